// File: rtl/sw_pkg.sv
// sw_pkg: shared types and helpers for the Smith-Waterman systolic engine.
//   state_t : controller FSM states
//   sym_t   : 2-bit nucleotide symbol
//   sat_sub : subtraction clamped at zero (scores never go negative)
package sw_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  typedef logic [1:0] sym_t;

  localparam int SAT_W = 32;

  // Callers widen their operands to SAT_W and truncate the result back.
  function automatic logic [SAT_W-1:0] sat_sub(input logic [SAT_W-1:0] a,
                                               input logic [SAT_W-1:0] b);
    return (a > b) ? (a - b) : '0;
  endfunction

endpackage

// File: rtl/sw_pe.sv
// sw_pe: one query-stationary processing element of the systolic array.
// Holds query symbol Q[j], the H/I/D registers of the cell it computed last,
// the one-cycle-delayed H of its left neighbour (diagonal input), and one
// stage of the reference/first-row-tag/valid pipeline.
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   run                array is processing a job (compute enable qualifier)
//   load_q, query      latch this PE's query symbol
//   ref_in/tag_in/v_in pipeline stage input from the left neighbour
//   h_left, i_left     left neighbour's H and I (column 0 for the first PE)
//   ref_out/tag_out/v_out  pipeline stage output to the right neighbour
//   h_out, i_out       this PE's H and I
//   h_valid            h_out holds a cell computed at the most recent edge
module sw_pe
  import sw_pkg::*;
#(
  parameter int WIDTH_SCORE = 8,
  parameter int MATCH       = 2,
  parameter int MISMATCH    = 1,
  parameter int GAP_OPEN    = 2,
  parameter int GAP_EXTEND  = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   run,
  input  logic                   load_q,
  input  sym_t                   query,
  input  sym_t                   ref_in,
  input  logic                   tag_in,
  input  logic                   v_in,
  input  logic [WIDTH_SCORE-1:0] h_left,
  input  logic [WIDTH_SCORE-1:0] i_left,
  output sym_t                   ref_out,
  output logic                   tag_out,
  output logic                   v_out,
  output logic [WIDTH_SCORE-1:0] h_out,
  output logic [WIDTH_SCORE-1:0] i_out,
  output logic                   h_valid
);

  localparam int W = WIDTH_SCORE;

  function automatic logic [W-1:0] csub(input logic [W-1:0] a, input int b);
    return W'(sat_sub(SAT_W'(a), SAT_W'(b)));
  endfunction

  function automatic logic [W-1:0] vmax(input logic [W-1:0] a, input logic [W-1:0] b);
    return (a > b) ? a : b;
  endfunction

  sym_t         q_r, ref_r;
  logic         tag_r, v_r, hv_r;
  logic [W-1:0] h_r, i_r, d_r, hdiag_r;
  logic [W-1:0] h_up, d_up, h_dg, diag, i_nxt, d_nxt, h_nxt;
  logic         en;

  assign en = v_r & run;

  always_comb begin
    // Row 1: the cell above and the diagonal cell lie on the zero boundary.
    h_up  = tag_r ? '0 : h_r;
    d_up  = tag_r ? '0 : d_r;
    h_dg  = tag_r ? '0 : hdiag_r;
    i_nxt = vmax(csub(h_left, GAP_OPEN), csub(i_left, GAP_EXTEND));
    d_nxt = vmax(csub(h_up, GAP_OPEN), csub(d_up, GAP_EXTEND));
    diag  = (ref_r == q_r) ? (h_dg + W'(MATCH)) : csub(h_dg, MISMATCH);
    h_nxt = vmax(diag, vmax(i_nxt, d_nxt));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_r     <= '0;
      ref_r   <= '0;
      tag_r   <= 1'b0;
      v_r     <= 1'b0;
      hv_r    <= 1'b0;
      h_r     <= '0;
      i_r     <= '0;
      d_r     <= '0;
      hdiag_r <= '0;
    end else begin
      if (load_q) q_r <= query;
      ref_r   <= ref_in;
      tag_r   <= tag_in;
      v_r     <= v_in;
      hdiag_r <= h_left;
      hv_r    <= en;
      if (en) begin
        h_r <= h_nxt;
        i_r <= i_nxt;
        d_r <= d_nxt;
      end
    end
  end

  assign ref_out = ref_r;
  assign tag_out = tag_r;
  assign v_out   = v_r;
  assign h_out   = h_r;
  assign i_out   = i_r;
  assign h_valid = hv_r;

endmodule

// File: rtl/sw_systolic.sv
// sw_systolic: Smith-Waterman local alignment with affine gaps on a
// query-stationary systolic array of QUERY_LEN PEs. The reference streams
// through the array while it is loaded; the best score and its 1-based end
// cell are reported with a one-cycle finish pulse.
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   valid                  job input strobe (REF_LEN contiguous cycles)
//   data_ref, data_query   R[k+1] / Q[k+1] during valid cycle k
//   ready                  high in IDLE
//   finish                 one-cycle pulse when max/pos are final
//   max, pos_ref, pos_query best H and its (i, j); all zero if no H > 0
// Handshake: a job starts on any edge where valid=1 and ready=1; valid must
// then stay high for REF_LEN cycles, dropping it early aborts the job.
module sw_systolic
  import sw_pkg::*;
#(
  parameter int REF_LEN         = 64,
  parameter int QUERY_LEN       = 48,
  parameter int WIDTH_SCORE     = 8,
  parameter int WIDTH_POS_REF   = 7,
  parameter int WIDTH_POS_QUERY = 6,
  parameter int MATCH           = 2,
  parameter int MISMATCH        = 1,
  parameter int GAP_OPEN        = 2,
  parameter int GAP_EXTEND      = 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       valid,
  input  sym_t                       data_ref,
  input  sym_t                       data_query,
  output logic                       ready,
  output logic                       finish,
  output logic [WIDTH_SCORE-1:0]     max,
  output logic [WIDTH_POS_REF-1:0]   pos_ref,
  output logic [WIDTH_POS_QUERY-1:0] pos_query
);

  localparam int LAST  = REF_LEN + QUERY_LEN;
  localparam int CNT_W = $clog2(LAST + 2);

  state_t             state, state_nxt;
  // cnt equals the index of the next edge, counted from the job's first edge.
  logic [CNT_W-1:0]   cnt;
  logic               start, accept, run;

  assign start  = valid && (state == IDLE);
  assign accept = valid && ((state == IDLE) || (state == LOAD));
  assign run    = (state == LOAD) || (state == DRAIN);
  assign ready  = (state == IDLE);
  assign finish = (state == DONE);

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (valid) state_nxt = LOAD;
      LOAD:  if (!valid) state_nxt = IDLE;
             else if (cnt == CNT_W'(REF_LEN - 1)) state_nxt = DRAIN;
      DRAIN: if (cnt == CNT_W'(LAST)) state_nxt = DONE;
      DONE:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= (state_nxt == IDLE) ? '0 : cnt + 1'b1;
    end
  end

  // Element 0 of each bus is the array's left edge (input stream, column 0).
  sym_t                   ref_b [0:QUERY_LEN];
  logic                   tag_b [0:QUERY_LEN];
  logic                   v_b   [0:QUERY_LEN];
  logic [WIDTH_SCORE-1:0] h_b   [0:QUERY_LEN];
  logic [WIDTH_SCORE-1:0] i_b   [0:QUERY_LEN];
  logic                   hv_b  [1:QUERY_LEN];

  assign ref_b[0] = data_ref;
  assign tag_b[0] = start;
  assign v_b[0]   = accept;
  assign h_b[0]   = '0;
  assign i_b[0]   = '0;

  for (genvar j = 1; j <= QUERY_LEN; j++) begin : g_pe
    sw_pe #(
      .WIDTH_SCORE (WIDTH_SCORE),
      .MATCH       (MATCH),
      .MISMATCH    (MISMATCH),
      .GAP_OPEN    (GAP_OPEN),
      .GAP_EXTEND  (GAP_EXTEND)
    ) u_pe (
      .clk     (clk),
      .rst     (reset),
      .run     (run),
      .load_q  (accept && (cnt == CNT_W'(j - 1))),
      .query   (data_query),
      .ref_in  (ref_b[j-1]),
      .tag_in  (tag_b[j-1]),
      // Leftovers of an aborted job are flushed from the pipeline in IDLE.
      .v_in    ((j == 1) ? v_b[0] : (v_b[j-1] & run)),
      .h_left  (h_b[j-1]),
      .i_left  (i_b[j-1]),
      .ref_out (ref_b[j]),
      .tag_out (tag_b[j]),
      .v_out   (v_b[j]),
      .h_out   (h_b[j]),
      .i_out   (i_b[j]),
      .h_valid (hv_b[j])
    );
  end

  // Anti-diagonal reduction. Scanning from the highest j down with a strict
  // compare keeps the largest j on a tie, i.e. the smallest i.
  logic [WIDTH_SCORE-1:0]     red_h;
  logic [WIDTH_POS_QUERY-1:0] red_j;
  logic [WIDTH_POS_REF-1:0]   red_i;

  always_comb begin
    red_h = '0;
    red_j = '0;
    for (int j = QUERY_LEN; j >= 1; j--) begin
      if (hv_b[j] && (h_b[j] > red_h)) begin
        red_h = h_b[j];
        red_j = WIDTH_POS_QUERY'(j);
      end
    end
  end

  // The cells in the PEs now were computed at edge cnt-1, so i = cnt - j.
  assign red_i = WIDTH_POS_REF'(cnt - CNT_W'(red_j));

  logic [WIDTH_SCORE-1:0]     best_h, best_h_nxt;
  logic [WIDTH_POS_REF-1:0]   best_i, best_i_nxt;
  logic [WIDTH_POS_QUERY-1:0] best_j, best_j_nxt;

  always_comb begin
    best_h_nxt = best_h;
    best_i_nxt = best_i;
    best_j_nxt = best_j;
    if (run && (red_h > best_h)) begin
      best_h_nxt = red_h;
      best_i_nxt = red_i;
      best_j_nxt = red_j;
    end
  end

  // Outputs are only loaded at completion, so an aborted job leaves them 0.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      best_h    <= '0;
      best_i    <= '0;
      best_j    <= '0;
      max       <= '0;
      pos_ref   <= '0;
      pos_query <= '0;
    end else if (start) begin
      best_h    <= '0;
      best_i    <= '0;
      best_j    <= '0;
      max       <= '0;
      pos_ref   <= '0;
      pos_query <= '0;
    end else begin
      best_h <= best_h_nxt;
      best_i <= best_i_nxt;
      best_j <= best_j_nxt;
      if ((state == DRAIN) && (cnt == CNT_W'(LAST))) begin
        max       <= best_h_nxt;
        pos_ref   <= best_i_nxt;
        pos_query <= best_j_nxt;
      end
    end
  end

endmodule

// File: tb/tb_sw_systolic.sv
// tb_sw_systolic: self-checking bench for sw_systolic. Two instances: the
// default 64x48 configuration and a small 8x4 one. Expected results come
// from a table of hand-derived vectors and from a full-matrix reference
// model of the alignment recurrences.
module tb_sw_systolic;

  localparam int RL  = 64;
  localparam int QL  = 48;
  localparam int SRL = 8;
  localparam int SQL = 4;
  localparam int P_MATCH = 2;
  localparam int P_MIS   = 1;
  localparam int P_GO    = 2;
  localparam int P_GE    = 1;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int edge_ctr = 0;
  always @(posedge clk) edge_ctr <= edge_ctr + 1;

  // ---------------- DUT signals ----------------
  logic       valid, ready, finish;
  logic [1:0] data_ref, data_query;
  logic [7:0] max_v;
  logic [6:0] pos_ref;
  logic [5:0] pos_query;

  logic       s_valid, s_ready, s_finish;
  logic [1:0] s_data_ref, s_data_query;
  logic [7:0] s_max;
  logic [3:0] s_pos_ref;
  logic [2:0] s_pos_query;

  sw_systolic u_dut (
    .clk        (clk),
    .reset      (reset),
    .valid      (valid),
    .data_ref   (data_ref),
    .data_query (data_query),
    .ready      (ready),
    .finish     (finish),
    .max        (max_v),
    .pos_ref    (pos_ref),
    .pos_query  (pos_query)
  );

  sw_systolic #(
    .REF_LEN         (SRL),
    .QUERY_LEN       (SQL),
    .WIDTH_SCORE     (8),
    .WIDTH_POS_REF   (4),
    .WIDTH_POS_QUERY (3)
  ) u_small (
    .clk        (clk),
    .reset      (reset),
    .valid      (s_valid),
    .data_ref   (s_data_ref),
    .data_query (s_data_query),
    .ready      (s_ready),
    .finish     (s_finish),
    .max        (s_max),
    .pos_ref    (s_pos_ref),
    .pos_query  (s_pos_query)
  );

  // ---------------- scoreboard state ----------------
  int n_tests = 0;
  int n_fail  = 0;
  int r_arr [1:64];
  int q_arr [1:48];
  int mh [0:64][0:48];
  int mi [0:64][0:48];
  int md [0:64][0:48];

  typedef struct {
    int rcode;   // 0..3 constant symbol, 4 = cycling 0,1,2,3
    int qcode;
    int exp_mx;
    int exp_pr;
    int exp_pq;
  } vec_t;
  vec_t tbl [5];

  task check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: actual %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int imax(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int sym_of(input int code, input int idx);
    return (code < 4) ? code : ((idx - 1) % 4);
  endfunction

  // Full-matrix reference; best cell chosen by scanning anti-diagonals in
  // order and rows ascending, taking only strictly larger scores.
  task model(input int rl, input int ql, output int mx, output int pr, output int pq);
    int s;
    for (int i = 0; i <= rl; i++)
      for (int j = 0; j <= ql; j++) begin
        mh[i][j] = 0; mi[i][j] = 0; md[i][j] = 0;
      end
    for (int i = 1; i <= rl; i++)
      for (int j = 1; j <= ql; j++) begin
        s = (r_arr[i] == q_arr[j]) ? P_MATCH : -P_MIS;
        mi[i][j] = imax(mh[i][j-1] - P_GO, mi[i][j-1] - P_GE);
        md[i][j] = imax(mh[i-1][j] - P_GO, md[i-1][j] - P_GE);
        mh[i][j] = imax(imax(0, mh[i-1][j-1] + s), imax(mi[i][j], md[i][j]));
      end
    mx = 0; pr = 0; pq = 0;
    for (int d = 2; d <= rl + ql; d++)
      for (int i = 1; i <= rl; i++) begin
        if ((d - i >= 1) && (d - i <= ql) && (mh[i][d-i] > mx)) begin
          mx = mh[i][d-i]; pr = i; pq = d - i;
        end
      end
  endtask

  // ---------------- driver tasks ----------------
  task set_in(input bit sm, input bit v, input int r, input int q);
    if (sm) begin
      s_valid = v; s_data_ref = 2'(r); s_data_query = 2'(q);
    end else begin
      valid = v; data_ref = 2'(r); data_query = 2'(q);
    end
  endtask

  task get_out(input bit sm, output int mx, output int pr, output int pq,
               output int fin, output int rdy);
    if (sm) begin
      mx = int'(s_max); pr = int'(s_pos_ref); pq = int'(s_pos_query);
      fin = int'(s_finish); rdy = int'(s_ready);
    end else begin
      mx = int'(max_v); pr = int'(pos_ref); pq = int'(pos_query);
      fin = int'(finish); rdy = int'(ready);
    end
  endtask

  // Runs one job from r_arr/q_arr. With b2b set it starts in the current
  // (ready) cycle and checks that the previous result holds, then clears.
  task automatic run_job(input bit sm, input bit noise, input bit b2b, input int prev_mx,
                         input int exp_mx, input int exp_pr, input int exp_pq,
                         input string tag);
    int rl, ql, start, mx, pr, pq, fin, rdy;
    bit seen;
    rl = sm ? SRL : RL;
    ql = sm ? SQL : QL;
    start = 0;
    seen = 1'b0;
    for (int k = 0; k < rl; k++) begin
      if (k > 0 || !b2b) @(negedge clk);
      get_out(sm, mx, pr, pq, fin, rdy);
      if (k == 0) begin
        start = edge_ctr;
        if (b2b) check({tag, " hold_max"}, mx, prev_mx);
      end
      if (k == 1 && b2b) begin
        check({tag, " clear_max"}, mx, 0);
        check({tag, " clear_pos_ref"}, pr, 0);
        check({tag, " clear_pos_query"}, pq, 0);
      end
      if (k == 2) check({tag, " busy_ready"}, rdy, 0);
      if (k < ql) set_in(sm, 1'b1, r_arr[k+1], q_arr[k+1]);
      else        set_in(sm, 1'b1, r_arr[k+1], int'($urandom_range(0, 3)));
    end
    for (int c = 0; c < ql + 20 && !seen; c++) begin
      @(negedge clk);
      get_out(sm, mx, pr, pq, fin, rdy);
      if (fin != 0) seen = 1'b1;
      else set_in(sm, noise ? 1'($urandom_range(0, 1)) : 1'b0,
                  int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
    end
    set_in(sm, 1'b0, 0, 0);
    check({tag, " finish_seen"}, int'(seen), 1);
    check({tag, " latency"}, edge_ctr - start - 1, rl + ql);
    check({tag, " max"}, mx, exp_mx);
    check({tag, " pos_ref"}, pr, exp_pr);
    check({tag, " pos_query"}, pq, exp_pq);
    @(negedge clk);
    get_out(sm, mx, pr, pq, fin, rdy);
    check({tag, " finish_pulse"}, fin, 0);
    check({tag, " ready_after"}, rdy, 1);
    check({tag, " max_held"}, mx, exp_mx);
  endtask

  task automatic rand_fill(input int rl, input int ql);
    int amax;
    amax = int'($urandom_range(1, 3));
    for (int i = 1; i <= rl; i++) r_arr[i] = int'($urandom_range(0, amax));
    for (int j = 1; j <= ql; j++) q_arr[j] = int'($urandom_range(0, amax));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int mx, pr, pq, fin, rdy, emx, epr, epq, prev, fin_cnt;

    tbl[0] = '{0, 0, 96, 48, 48};
    tbl[1] = '{0, 1, 0, 0, 0};
    tbl[2] = '{3, 3, 96, 48, 48};
    tbl[3] = '{4, 4, 96, 48, 48};
    tbl[4] = '{2, 1, 0, 0, 0};

    reset = 1'b1;
    set_in(1'b0, 1'b0, 0, 0);
    set_in(1'b1, 1'b0, 0, 0);
    repeat (2) @(negedge clk);
    for (int sm = 0; sm < 2; sm++) begin
      get_out(sm[0], mx, pr, pq, fin, rdy);
      check("reset ready", rdy, 1);
      check("reset finish", fin, 0);
      check("reset max", mx, 0);
      check("reset pos_ref", pr, 0);
      check("reset pos_query", pq, 0);
    end
    reset = 1'b0;

    // Table vectors on the default instance.
    for (int t = 0; t < 5; t++) begin
      for (int i = 1; i <= RL; i++) r_arr[i] = sym_of(tbl[t].rcode, i);
      for (int j = 1; j <= QL; j++) q_arr[j] = sym_of(tbl[t].qcode, j);
      run_job(1'b0, 1'b0, 1'b0, 0, tbl[t].exp_mx, tbl[t].exp_pr, tbl[t].exp_pq,
              $sformatf("vec%0d", t));
    end

    // Small instance: one-gap alignment.
    q_arr[1] = 0; q_arr[2] = 1; q_arr[3] = 2; q_arr[4] = 3;
    r_arr[1] = 3; r_arr[2] = 3; r_arr[3] = 0; r_arr[4] = 1;
    r_arr[5] = 0; r_arr[6] = 2; r_arr[7] = 3; r_arr[8] = 3;
    run_job(1'b1, 1'b0, 1'b0, 0, 6, 7, 4, "small_gap");

    // Back-to-back: noise on valid while draining, second job on ready cycle.
    rand_fill(RL, QL);
    model(RL, QL, emx, epr, epq);
    run_job(1'b0, 1'b1, 1'b0, 0, emx, epr, epq, "b2b_a");
    prev = emx;
    rand_fill(RL, QL);
    model(RL, QL, emx, epr, epq);
    run_job(1'b0, 1'b0, 1'b1, prev, emx, epr, epq, "b2b_b");

    // Abort after 10 valid cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 0, 0);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 0, 0);
    @(negedge clk);
    get_out(1'b0, mx, pr, pq, fin, rdy);
    check("abort ready", rdy, 1);
    check("abort max", mx, 0);
    check("abort pos_ref", pr, 0);
    check("abort pos_query", pq, 0);
    fin_cnt = 0;
    repeat (130) begin
      @(negedge clk);
      get_out(1'b0, mx, pr, pq, fin, rdy);
      if (fin != 0) fin_cnt++;
    end
    check("abort no_finish", fin_cnt, 0);
    check("abort max_later", mx, 0);

    // Reset pulsed while draining, then a full job.
    for (int k = 0; k < RL; k++) begin
      @(negedge clk);
      set_in(1'b0, 1'b1, 0, 0);
    end
    @(negedge clk);
    set_in(1'b0, 1'b0, 0, 0);
    repeat (10) @(negedge clk);
    get_out(1'b0, mx, pr, pq, fin, rdy);
    check("drain ready_low", rdy, 0);
    reset = 1'b1;
    #1;
    get_out(1'b0, mx, pr, pq, fin, rdy);
    check("midrst ready", rdy, 1);
    check("midrst finish", fin, 0);
    check("midrst max", mx, 0);
    check("midrst pos_ref", pr, 0);
    check("midrst pos_query", pq, 0);
    @(negedge clk);
    reset = 1'b0;
    rand_fill(RL, QL);
    model(RL, QL, emx, epr, epq);
    run_job(1'b0, 1'b0, 1'b0, 0, emx, epr, epq, "post_rst");

    // Randomized jobs against the reference model.
    for (int n = 0; n < 3; n++) begin
      rand_fill(RL, QL);
      model(RL, QL, emx, epr, epq);
      run_job(1'b0, 1'b1, 1'b0, 0, emx, epr, epq, $sformatf("rand%0d", n));
    end
    for (int n = 0; n < 6; n++) begin
      rand_fill(SRL, SQL);
      model(SRL, SQL, emx, epr, epq);
      run_job(1'b1, 1'b1, 1'b0, 0, emx, epr, epq, $sformatf("srand%0d", n));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
